// File: rtl/dmem_byte_arbiter_pkg.sv
// dmem_arb_pkg: shared types and constants for the byte-serial data memory
// arbiter (state encoding, beat count, port identifiers, byte-lane helper).
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int   BEATS    = 4;
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

  // Big-endian lane for a beat: beat 0 carries bits 31:24, beat 3 bits 7:0.
  function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] beat);
    logic [7:0] lane;
    case (beat)
      2'd0:    lane = word[31:24];
      2'd1:    lane = word[23:16];
      2'd2:    lane = word[15:8];
      default: lane = word[7:0];
    endcase
    return lane;
  endfunction

endpackage

// File: rtl/dmem_byte_arbiter_if.sv
// dmem_byte_arbiter_if: both word requesters plus the byte memory port.
// The arbiter uses the slave modport (it serves the requesters and owns the
// memory strobes); the environment (requesters + memory) uses master.
// err0/err1 exist only when DMEM_ARB_ALIGN_CHECK_EN is defined.
interface dmem_byte_arbiter_if #(
  parameter int ADDR_W = 5
);

  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [31:0]       wdata0;
  logic              ack0;
  logic [31:0]       rdata0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [31:0]       wdata1;
  logic              ack1;
  logic [31:0]       rdata1;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  logic              busy;
  logic              gnt_id;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
  logic              err0;
  logic              err1;
`endif

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  mem_rdata,
    output ack0, rdata0, ack1, rdata1,
    output mem_addr, mem_we, mem_wdata,
    output busy, gnt_id
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    , output err0, err1
`endif
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output mem_rdata,
    input  ack0, rdata0, ack1, rdata1,
    input  mem_addr, mem_we, mem_wdata,
    input  busy, gnt_id
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    , input err0, err1
`endif
  );

endinterface

// File: rtl/dmem_byte_arbiter_rr_arb2.sv
// rr_arb2: combinational two-requester round-robin picker. On a tie the port
// that did not win last time is chosen; the last winner is held by the parent.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic       valid,
  output logic       winner
);

  // Winner selection: a lone requester wins outright, a tie alternates.
  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    valid  = |req;
    winner = PORT_CPU;
    if (req == 2'b11) begin
      winner = ~last_gnt;
    end else if (req[1]) begin
      winner = PORT_LDR;
    end
  end

endmodule

// File: rtl/dmem_byte_arbiter.sv
// dmem_byte_arbiter: shares a byte-wide data memory between a CPU port (0)
// and a loader/debug port (1). Each 32-bit access becomes four big-endian
// byte beats at base, base+1, base+2, base+3 (wrapping modulo 2**ADDR_W).
// Memory strobes are decoded from registered state only, never from req.
// Optional: define DMEM_ARB_ALIGN_CHECK_EN to reject addresses with
// addr[1:0] != 0 (ack with err, no memory access). DATA_W must stay 32.
module dmem_byte_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input logic                clk,
  input logic                reset,
  dmem_byte_arbiter_if.slave bus
);

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        beat;
  logic              last_gnt;
  logic              gnt_id;
  logic              cur_we;
  logic [ADDR_W-1:0] base;
  logic [DATA_W-1:0] wdata_q;
  logic [23:0]       stage;      // bytes from beats 0..2; beat 3 goes straight to rdata
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;

  logic              arb_valid;
  logic              arb_winner;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic [ADDR_W-1:0] mem_addr_d;
  logic              mem_we_d;
  logic [7:0]        mem_wdata_d;
  logic              ack0_d;
  logic              ack1_d;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  logic              err_q;
  logic              unaligned;
  assign unaligned = (sel_addr[1:0] != 2'b00);
`endif

  rr_arb2 u_rr_arb2 (
    .req      ({bus.req1, bus.req0}),
    .last_gnt (last_gnt),
    .valid    (arb_valid),
    .winner   (arb_winner)
  );

  // Request fields of whichever port the picker chose.
  always_comb begin
    sel_we    = bus.we0;
    sel_addr  = bus.addr0;
    sel_wdata = bus.wdata0;
    if (arb_winner == PORT_LDR) begin
      sel_we    = bus.we1;
      sel_addr  = bus.addr1;
      sel_wdata = bus.wdata1;
    end
  end

  // State register; reset aborts any transfer in flight.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: arbitrate in IDLE, four beats in XFER, one ack cycle in RESP.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (arb_valid) begin
`ifdef DMEM_ARB_ALIGN_CHECK_EN
          state_nxt = unaligned ? RESP : XFER;
`else
          state_nxt = XFER;
`endif
        end
      end
      XFER:    if (beat == 2'(BEATS - 1)) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Transfer datapath: latch the grant, advance beats, collect read bytes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat     <= 2'd0;
      last_gnt <= PORT_LDR;
      gnt_id   <= PORT_CPU;
      cur_we   <= 1'b0;
      base     <= '0;
      wdata_q  <= '0;
      stage    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (arb_valid) begin
            gnt_id  <= arb_winner;
            cur_we  <= sel_we;
            base    <= sel_addr;
            wdata_q <= sel_wdata;
            beat    <= 2'd0;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
            err_q   <= unaligned;
            if (unaligned) begin
              last_gnt <= arb_winner;
              if (arb_winner == PORT_LDR) rdata1_q <= '0;
              else                        rdata0_q <= '0;
            end
`endif
          end
        end
        XFER: begin
          beat <= beat + 2'd1;
          if (!cur_we) begin
            case (beat)
              2'd0: stage[23:16] <= bus.mem_rdata;
              2'd1: stage[15:8]  <= bus.mem_rdata;
              2'd2: stage[7:0]   <= bus.mem_rdata;
              default: begin
                if (gnt_id == PORT_LDR) rdata1_q <= {stage, bus.mem_rdata};
                else                    rdata0_q <= {stage, bus.mem_rdata};
              end
            endcase
          end
          if (beat == 2'(BEATS - 1)) begin
            last_gnt <= gnt_id;
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode from registered state only.
  always_comb begin
    mem_addr_d  = '0;
    mem_we_d    = 1'b0;
    mem_wdata_d = 8'h00;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    if (state == XFER) begin
      mem_addr_d = base + ADDR_W'(beat);
      mem_we_d   = cur_we;
      if (cur_we) mem_wdata_d = byte_lane(wdata_q, beat);
    end
    if (state == RESP) begin
      ack0_d = (gnt_id == PORT_CPU);
      ack1_d = (gnt_id == PORT_LDR);
    end
  end

  assign bus.mem_addr  = mem_addr_d;
  assign bus.mem_we    = mem_we_d;
  assign bus.mem_wdata = mem_wdata_d;
  assign bus.ack0      = ack0_d;
  assign bus.ack1      = ack1_d;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;
  assign bus.busy      = (state != IDLE);
  assign bus.gnt_id    = gnt_id;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
  assign bus.err0      = ack0_d & err_q;
  assign bus.err1      = ack1_d & err_q;
`endif

endmodule
